// File: rtl/acq_timer_ctrl.sv
// Start/stop sequencer for the 32-bit acquisition timer with tick divider and
// event timestamping (count + wrap epoch) onto a valid/ready output.
module acq_timer_ctrl #(
  parameter int PERIOD_W = 16,
  parameter int EPOCH_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic [PERIOD_W-1:0] tick_period,
  input  logic [31:0]         timer_count,
  input  logic                timer_full,
  input  logic                timer_tick,
  input  logic                evt,
  input  logic                ts_ready,
  output logic                timer_clr,
  output logic                timer_ena,
  output logic                trig,
  output logic [31:0]         ts_data,
  output logic [EPOCH_W-1:0]  ts_epoch,
  output logic                ts_valid,
  output logic                busy,
  output logic                ovf_err
);

  typedef enum logic [1:0] {IDLE, CLR, RUN} state_t;

  state_t              state, state_nxt;
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] tick_cnt;
  logic [EPOCH_W-1:0]  epoch;
  logic [EPOCH_W-1:0]  epoch_inc;
  logic                enter_clr;
  logic                ts_take;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CLR;
      CLR:     state_nxt = RUN;
      RUN:     if (start) state_nxt = CLR;
               else if (stop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign enter_clr = (state_nxt == CLR);
  assign epoch_inc = epoch + EPOCH_W'(1);
  assign ts_take   = ts_valid && ts_ready;

  // Registered outputs track the state being entered, so they change one cycle after the command.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_clr <= 1'b0;
      timer_ena <= 1'b0;
      busy      <= 1'b0;
    end else begin
      timer_clr <= (state_nxt == CLR);
      timer_ena <= (state_nxt == RUN);
      busy      <= (state_nxt != IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period   <= '0;
      tick_cnt <= '0;
      epoch    <= '0;
      trig     <= 1'b0;
      ts_data  <= '0;
      ts_epoch <= '0;
      ts_valid <= 1'b0;
      ovf_err  <= 1'b0;
    end else begin
      trig <= 1'b0;
      if (enter_clr) begin
        period   <= tick_period;
        tick_cnt <= '0;
        epoch    <= '0;
        ovf_err  <= 1'b0;
        ts_valid <= 1'b0;
      end else if (state == RUN) begin
        if (timer_tick && (period != '0)) begin
          if (tick_cnt == period - PERIOD_W'(1)) begin
            trig     <= 1'b1;
            tick_cnt <= '0;
          end else begin
            tick_cnt <= tick_cnt + PERIOD_W'(1);
          end
        end
        if (timer_full) epoch <= epoch_inc;
        // A capture in the same cycle as a handshake replaces the drained entry without a bubble.
        if (evt && (!ts_valid || ts_take)) begin
          ts_data  <= timer_count;
          ts_epoch <= timer_full ? epoch_inc : epoch;
          ts_valid <= 1'b1;
        end else begin
          if (evt) ovf_err <= 1'b1;
          if (ts_take) ts_valid <= 1'b0;
        end
      end else if (ts_take) begin
        ts_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_acq_timer_ctrl.sv
// Directed bench for acq_timer_ctrl: sequencing, divider, epoch and timestamp handshake.
module tb_acq_timer_ctrl;
  localparam int PERIOD_W = 16;
  localparam int EPOCH_W  = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start = 1'b0, stop = 1'b0;
  logic [PERIOD_W-1:0] tick_period = '0;
  logic [31:0]         timer_count = '0;
  logic                timer_full = 1'b0, timer_tick = 1'b0;
  logic                evt = 1'b0, ts_ready = 1'b0;
  logic                timer_clr, timer_ena, trig, ts_valid, busy, ovf_err;
  logic [31:0]         ts_data;
  logic [EPOCH_W-1:0]  ts_epoch;

  int checks = 0;
  int errors = 0;
  int trig_seen = 0;

  acq_timer_ctrl #(.PERIOD_W(PERIOD_W), .EPOCH_W(EPOCH_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .tick_period(tick_period),
    .timer_count(timer_count), .timer_full(timer_full), .timer_tick(timer_tick),
    .evt(evt), .ts_ready(ts_ready), .timer_clr(timer_clr), .timer_ena(timer_ena),
    .trig(trig), .ts_data(ts_data), .ts_epoch(ts_epoch), .ts_valid(ts_valid),
    .busy(busy), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (trig) trig_seen++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
  endtask

  function automatic logic [47:0] outs();
    return {timer_clr, timer_ena, trig, ts_valid, busy, ovf_err, ts_data, ts_epoch};
  endfunction

  initial begin
    #23;
    chk("reset_outputs", 64'(outs()), 64'h0);
    rst = 1'b1;
    step();

    // Idle ignores stop and evt
    stop = 1'b1; evt = 1'b1; timer_count = 32'hABCD;
    step();
    stop = 1'b0; evt = 1'b0;
    step();
    chk("idle_quiet", 64'(outs()), 64'h0);

    // Start sequencing with divider ratio 3
    tick_period = 16'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("clr_cycle_clr", 64'(timer_clr), 64'h1);
    chk("clr_cycle_ena", 64'(timer_ena), 64'h0);
    chk("clr_cycle_busy", 64'(busy), 64'h1);
    step();
    chk("run_clr", 64'(timer_clr), 64'h0);
    chk("run_ena", 64'(timer_ena), 64'h1);

    trig_seen = 0;
    for (int k = 1; k <= 10; k++) begin
      timer_tick = 1'b1;
      step();
      timer_tick = 1'b0;
      chk($sformatf("trig_tick%0d", k), 64'(trig), (k % 3 == 0) ? 64'h1 : 64'h0);
      repeat (3) step();
    end
    chk("trig_total_p3", 64'(trig_seen), 64'd3);

    // Divider disabled
    tick_period = 16'd0;
    restart();
    trig_seen = 0;
    for (int k = 0; k < 5; k++) begin
      timer_tick = 1'b1;
      step();
      timer_tick = 1'b0;
      step();
    end
    chk("trig_total_p0", 64'(trig_seen), 64'd0);

    // Capture held while ready is low, second event overflows
    timer_count = 32'h0000_1234; evt = 1'b1;
    step();
    evt = 1'b0; timer_count = 32'h0000_9999;
    chk("ts_valid_cap", 64'(ts_valid), 64'h1);
    chk("ts_data_cap", 64'(ts_data), 64'h1234);
    chk("ts_epoch_cap", 64'(ts_epoch), 64'h0);
    repeat (4) step();
    chk("ts_data_hold", 64'(ts_data), 64'h1234);
    chk("ovf_before", 64'(ovf_err), 64'h0);
    evt = 1'b1;
    step();
    evt = 1'b0;
    chk("ovf_set", 64'(ovf_err), 64'h1);
    chk("ts_data_ovf", 64'(ts_data), 64'h1234);
    ts_ready = 1'b1;
    step();
    ts_ready = 1'b0;
    chk("ts_drain", 64'(ts_valid), 64'h0);
    chk("ovf_sticky", 64'(ovf_err), 64'h1);

    // Back-to-back capture on handshake
    restart();
    chk("ovf_cleared", 64'(ovf_err), 64'h0);
    timer_count = 32'h40; evt = 1'b1;
    step();
    chk("b2b_first", 64'(ts_data), 64'h40);
    timer_count = 32'h50; ts_ready = 1'b1;
    step();
    evt = 1'b0;
    chk("b2b_valid", 64'(ts_valid), 64'h1);
    chk("b2b_data", 64'(ts_data), 64'h50);
    chk("b2b_ovf", 64'(ovf_err), 64'h0);
    step();
    ts_ready = 1'b0;
    chk("b2b_drain", 64'(ts_valid), 64'h0);

    // Epoch wrap: 257 wraps -> epoch 1
    timer_full = 1'b1;
    repeat (257) step();
    timer_full = 1'b0;
    timer_count = 32'h77; evt = 1'b1;
    step();
    evt = 1'b0;
    chk("epoch_wrap", 64'(ts_epoch), 64'h1);
    ts_ready = 1'b1; step(); ts_ready = 1'b0;
    timer_count = 32'h0; evt = 1'b1; timer_full = 1'b1;
    step();
    evt = 1'b0; timer_full = 1'b0;
    chk("epoch_coincident", 64'(ts_epoch), 64'h2);
    ts_ready = 1'b1; step(); ts_ready = 1'b0;
    evt = 1'b1;
    step();
    chk("epoch_after", 64'(ts_epoch), 64'h2);
    step();
    evt = 1'b0;
    chk("ovf_pre_restart", 64'(ovf_err), 64'h1);

    // start and stop together restart the run
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("restart_clr", 64'(timer_clr), 64'h1);
    chk("restart_ena", 64'(timer_ena), 64'h0);
    step();
    chk("restart_run", 64'(timer_ena), 64'h1);
    chk("restart_ovf", 64'(ovf_err), 64'h0);
    chk("restart_tsv", 64'(ts_valid), 64'h0);
    timer_count = 32'hC0FFEE; evt = 1'b1;
    step();
    evt = 1'b0;
    chk("restart_epoch", 64'(ts_epoch), 64'h0);

    // Stop keeps the pending timestamp, drained in idle
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_ena", 64'(timer_ena), 64'h0);
    chk("stop_busy", 64'(busy), 64'h0);
    chk("stop_tsv", 64'(ts_valid), 64'h1);
    evt = 1'b1;
    step();
    evt = 1'b0;
    chk("idle_evt_no_ovf", 64'(ovf_err), 64'h0);
    chk("idle_ts_data", 64'(ts_data), 64'hC0FFEE);
    ts_ready = 1'b1; step(); ts_ready = 1'b0;
    chk("idle_drain", 64'(ts_valid), 64'h0);

    // Asynchronous reset mid-run
    tick_period = 16'd1;
    restart();
    timer_tick = 1'b1; evt = 1'b1;
    step();
    timer_tick = 1'b0; evt = 1'b0;
    chk("pre_rst_trig", 64'(trig), 64'h1);
    #2 rst = 1'b0;
    #1;
    chk("rst_async_outs", 64'(outs()), 64'h0);
    step();
    #2 rst = 1'b1;
    step();
    chk("post_rst_outs", 64'(outs()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/acq_timer_ctrl.md
Name: acq_timer_ctrl

Overview:
Sequencing controller for the 32-bit acquisition timer (clr/ena/count/pulse_full/tick interface). Handles start/stop commands and clears the timer on each start. Divides the timer's tick pulse into a programmable acquisition trigger. Timestamps external events (count plus wrap epoch) onto a valid/ready interface toward the acquisition datapath.

Parameters:
PERIOD_W, 16, width of tick_period, the trigger divider ratio
EPOCH_W, 8, width of the wrap-epoch counter appended to timestamps

Ports:
clk  input  1  working clock (110.592 MHz domain)
rst  input  1  asynchronous, active-low reset
start  input  1  one-cycle command: clear timer and begin run (also restarts when already running)
stop  input  1  one-cycle command: halt run, timer holds value
tick_period  input  PERIOD_W  ticks per trigger; sampled on entry to CLR; 0 = trigger disabled
timer_count  input  32  timer count value
timer_full  input  1  timer wrap pulse (count was 0xFFFFFFFF)
timer_tick  input  1  timer periodic tick pulse
evt  input  1  one-cycle event strobe to timestamp
ts_ready  input  1  downstream accepts timestamp
timer_clr  output  1  to timer clr
timer_ena  output  1  to timer ena
trig  output  1  one-cycle acquisition trigger
ts_data  output  32  captured timer_count
ts_epoch  output  EPOCH_W  captured epoch
ts_valid  output  1  timestamp valid
busy  output  1  high in CLR or RUN
ovf_err  output  1  sticky: event dropped because the output was full

Behaviour:
- Reset (rst=0): state IDLE. All outputs 0, all internal counters 0, period register 0.
- State IDLE:
  - timer_clr=0, timer_ena=0.
  - start -> CLR. stop is ignored. evt is ignored.
- State CLR, exactly one cycle:
  - timer_clr=1, timer_ena=0, busy=1.
  - Latches tick_period into the period register.
  - Clears tick_cnt, epoch and ovf_err.
  - Drops any pending timestamp (ts_valid=0).
  - Next state RUN unconditionally; start/stop in this cycle are ignored.
- State RUN:
  - timer_ena=1, busy=1.
  - stop -> IDLE; timer_ena=0 from the next cycle.
  - start -> CLR (restart); start has priority over stop when both are high.
- Outputs are registered; every output change appears the cycle after its cause.
- Trigger divider (RUN only):
  - On timer_tick with period register P != 0: if tick_cnt == P-1, then trig=1 for one cycle and tick_cnt=0; otherwise tick_cnt+1.
  - P=1 gives a trigger on every tick. P=0 never triggers.
  - Ticks in IDLE/CLR are ignored; tick_cnt holds in IDLE.
- Epoch (RUN only):
  - timer_full increments epoch, wrapping modulo 2^EPOCH_W.
  - epoch holds in IDLE.
- Timestamp capture (RUN only):
  - evt with ts_valid=0: ts_data<=timer_count, ts_epoch<=epoch (or epoch+1 if timer_full is in the same cycle), ts_valid<=1.
  - ts_valid stays high and ts_data/ts_epoch stay stable until ts_valid && ts_ready; then ts_valid<=0.
  - evt in the same cycle as ts_valid && ts_ready: the new capture is accepted and ts_valid stays 1 with the new data (no bubble).
  - evt with ts_valid=1 and ts_ready=0: event dropped, ovf_err<=1. ovf_err is cleared only by CLR or reset.
  - A pending timestamp survives stop and is drained in IDLE. evt in IDLE is ignored and does not set ovf_err.
- Reset asserted mid-run: immediate return to IDLE values; no trig or timer_clr glitch after release.

Test Plan:
- Reset, start at cycle 5 -> timer_clr=1 in cycle 6 only; timer_ena=1 from cycle 7; busy=1 from cycle 6.
- tick_period=3, 10 ticks pulsed every 4 cycles -> trig on ticks 3, 6 and 9 only (3 pulses, each 1 cycle); tick_period=0 -> no trig.
- evt with timer_count=0x00001234, ts_ready=0 for 5 cycles -> ts_valid=1, ts_data=0x00001234 held stable; second evt -> ovf_err=1 and ts_data unchanged; ts_ready=1 -> ts_valid=0 next cycle.
- ts_valid=1, evt and ts_ready in the same cycle with count=0x50 -> ts_valid stays 1, ts_data=0x50, ovf_err stays 0.
- timer_full pulsed 257 times with EPOCH_W=8 -> epoch wraps to 1; evt coincident with timer_full -> ts_epoch=epoch+1.
- start+stop together in RUN -> CLR then RUN (restart, epoch=0, ovf_err=0). stop -> timer_ena=0 next cycle. rst low mid-run -> all outputs 0 immediately.
